// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control sequencer for the 32-bit multicycle datapath
// Moore state decode plus mem_ready/zero-qualified strobes, retire counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        alu_src_a,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        illegal_op,
    output logic        retired,
    output logic [31:0] instr_count,
    output logic [3:0]  state_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instr_count_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IMM_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_ALU_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        retired    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR, S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retired   = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retired   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                retired   = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retired  = 1'b1;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        // Strobes must not leak out while the reset is held, even though FETCH drives mem_read.
        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
            retired    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retired) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

    assign instr_count = instr_count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
    localparam int EXEC = 6, ALU_WB = 7, BRANCH = 8, JUMP = 9, IMM_EXEC = 10, IMM_WB = 11;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, rw, mrd, mwr, iod, sa, rd, m2r;
        logic [1:0]  sb, ps, aop;
        logic        ill, ret;
        logic [31:0] cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    logic        i_or_d, alu_src_a, reg_dst, mem_to_reg;
    logic [1:0]  alu_src_b, pc_src, alu_op;
    logic        illegal_op, retired;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'd0;
    rec_t        expq[$];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .illegal_op(illegal_op), .retired(retired), .instr_count(instr_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    // Expected outputs of one cycle of an instruction phase, straight from the state table.
    function automatic rec_t model(input int ph, input logic mr, input logic z, input logic [5:0] op);
        rec_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            FETCH:    begin e.mrd = 1; e.sb = 2'b01; e.irw = mr; e.pcw = mr; end
            DECODE:   begin e.sb = 2'b10; e.ill = !is_legal(op); end
            MEM_ADDR: begin e.sa = 1; e.sb = 2'b10; end
            MEM_RD:   begin e.mrd = 1; e.iod = 1; end
            MEM_WB:   begin e.rw = 1; e.m2r = 1; e.ret = 1; end
            MEM_WR:   begin e.mwr = 1; e.iod = 1; e.ret = mr; end
            EXEC:     begin e.sa = 1; e.aop = 2'b10; end
            ALU_WB:   begin e.rw = 1; e.rd = 1; e.ret = 1; end
            BRANCH:   begin e.sa = 1; e.aop = 2'b01; e.ps = 2'b01; e.pcw = z; e.ret = 1; end
            JUMP:     begin e.ps = 2'b10; e.pcw = 1; e.ret = 1; end
            IMM_EXEC: begin e.sa = 1; e.sb = 2'b10; end
            IMM_WB:   begin e.rw = 1; e.ret = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle and queue what the DUT should show during it.
    task automatic step(input int ph, input logic mr, input logic z, input logic [5:0] op);
        rec_t e;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        e = model(ph, mr, z, op);
        e.cnt = exp_count;
        expq.push_back(e);
        if (e.ret) exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input logic z);
        for (int i = 0; i < fs; i++) step(FETCH, 1'b0, rb(), 6'($urandom));
        step(FETCH, 1'b1, rb(), 6'($urandom));
        step(DECODE, rb(), rb(), op);
        case (op)
            OP_LW: begin
                step(MEM_ADDR, rb(), rb(), op);
                for (int i = 0; i < ms; i++) step(MEM_RD, 1'b0, rb(), op);
                step(MEM_RD, 1'b1, rb(), op);
                step(MEM_WB, rb(), rb(), op);
            end
            OP_SW: begin
                step(MEM_ADDR, rb(), rb(), op);
                for (int i = 0; i < ms; i++) step(MEM_WR, 1'b0, rb(), op);
                step(MEM_WR, 1'b1, rb(), op);
            end
            OP_RTYPE: begin step(EXEC, rb(), rb(), op); step(ALU_WB, rb(), rb(), op); end
            OP_ADDI:  begin step(IMM_EXEC, rb(), rb(), op); step(IMM_WB, rb(), rb(), op); end
            OP_BEQ:   step(BRANCH, rb(), z, op);
            OP_J:     step(JUMP, rb(), rb(), op);
            default:  ;
        endcase
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_state"}, 64'(state_o), 64'd0);
        chk({name, "_count"}, 64'(instr_count), 64'd0);
        chk({name, "_enables"},
            64'({pc_write, ir_write, reg_write, mem_read, mem_write, illegal_op, retired}), 64'd0);
        chk({name, "_alu_src_b"}, 64'(alu_src_b), 64'd1);
    endtask

    always @(negedge clk) begin
        rec_t a, e;
        a = {state_o, pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, alu_src_a,
             reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op, illegal_op, retired, instr_count};
        checks++;
        if (alu_src_b == 2'b11 || pc_src == 2'b11) begin
            errors++;
            $display("FAIL select_range: alu_src_b=%0d pc_src=%0d, neither may be 3", alu_src_b, pc_src);
        end
        if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs: state %0d got %h expected %h", e.st, a, e);
            end
        end
    end

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_init");
        rst_n = 1'b1;

        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(6'h3F, 0, 0, 1'b0);
        chk("count_after_seq", 64'(instr_count), 64'd3);

        run_instr(OP_LW, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 3, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        chk("count_after_mem_br", 64'(instr_count), 64'd7);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        mem_ready = 1'b0;
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        exp_count = 32'hFFFF_FFFF;
        run_instr(OP_J, 0, 0, 1'b0);
        chk("count_wrap", 64'(instr_count), 64'd0);

        run_instr(OP_J, 0, 0, 1'b0);
        step(FETCH, 1'b1, 1'b0, 6'h00);
        step(DECODE, 1'b1, 1'b0, OP_LW);
        step(MEM_ADDR, 1'b1, 1'b0, OP_LW);
        step(MEM_RD, 1'b1, 1'b0, OP_LW);
        chk("in_mem_wb", 64'(state_o), 64'(MEM_WB));
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_wb");
        exp_count = 32'd0;
        @(posedge clk);
        #1;
        chk_reset("reset_held");
        rst_n = 1'b1;
        run_instr(OP_J, 0, 0, 1'b0);
        chk("count_after_reset", 64'(instr_count), 64'd1);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
